// File: rtl/uart_tx_param.sv
// uart_tx_param: double-buffered UART transmitter with runtime parity, stop-bit count and baud divisor.
// Define UART_TX_BREAK_EN to add the Tx_BREAK input and line-break generation.
module uart_tx_param #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] Tx_DATA,
    input  logic              Tx_WR,
    input  logic              Tx_EN,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [1:0]        parity_mode,
    input  logic              two_stop,
`ifdef UART_TX_BREAK_EN
    input  logic              Tx_BREAK,
`endif
    output logic              TxD,
    output logic              Tx_BUSY,
    output logic              Tx_READY,
    output logic              Tx_DONE,
    output logic              Tx_OVR
);

    localparam int unsigned SCW = $clog2(OVERSAMPLE);
    localparam int unsigned BCW = 4;

`ifdef UART_TX_BREAK_EN
    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2
    } state_t;
`endif

    state_t            state, state_n;
    logic [DATA_W-1:0] shift_q, shift_n;
    logic [DATA_W-1:0] hold_q, hold_n;
    logic [BCW-1:0]    bit_cnt, bit_cnt_n;
    logic [SCW-1:0]    samp_cnt, samp_n;
    logic [DIV_W-1:0]  div_cnt, div_n;
    logic              par_en_q, par_en_n;
    logic              par_bit_q, par_bit_n;
    logic              two_stop_q, two_stop_n;
    logic              txd_n, busy_n, ready_n, done_n, ovr_n;
    logic              tick, bit_end, frame_end, load;
    logic              brk_mark;

`ifdef UART_TX_BREAK_EN
    logic              brk_mark_q, brk_mark_n;
    logic [BCW-1:0]    brk_last;

    assign brk_mark = brk_mark_q;
    // Index of the last bit period of one full frame under the latched config.
    assign brk_last = BCW'(DATA_W + 1) + BCW'(par_en_q) + BCW'(two_stop_q);
`else
    assign brk_mark = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        shift_n    = shift_q;
        hold_n     = hold_q;
        bit_cnt_n  = bit_cnt;
        samp_n     = samp_cnt;
        div_n      = div_cnt;
        par_en_n   = par_en_q;
        par_bit_n  = par_bit_q;
        two_stop_n = two_stop_q;
        ready_n    = Tx_READY;
        done_n     = 1'b0;
        ovr_n      = 1'b0;
        frame_end  = 1'b0;
        load       = 1'b0;
`ifdef UART_TX_BREAK_EN
        brk_mark_n = brk_mark_q;
`endif

        tick    = (div_cnt == baud_div);
        bit_end = tick && (samp_cnt == SCW'(OVERSAMPLE - 1));

        if (tick) begin
            div_n  = '0;
            samp_n = bit_end ? '0 : samp_cnt + 1'b1;
        end else begin
            div_n  = div_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                div_n  = '0;
                samp_n = '0;
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_n = shift_q >> 1;
                    if (bit_cnt == BCW'(DATA_W - 1)) begin
                        state_n = par_en_q ? PARITY : STOP1;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP1;
                end
            end
            STOP1: begin
                if (bit_end) begin
                    if (two_stop_q && !brk_mark) begin
                        state_n = STOP2;
                    end else begin
                        frame_end = 1'b1;
                        done_n    = !brk_mark;
                    end
                end
            end
            STOP2: begin
                if (bit_end) begin
                    frame_end = 1'b1;
                    done_n    = 1'b1;
                end
            end
`ifdef UART_TX_BREAK_EN
            BREAK: begin
                if (bit_end) begin
                    if (bit_cnt >= brk_last) begin
                        if (!Tx_BREAK) begin
                            state_n    = STOP1;
                            brk_mark_n = 1'b1;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_n = IDLE;
                div_n   = '0;
                samp_n  = '0;
            end
        endcase

        // Frame dispatch: from IDLE, or chained directly off the last stop bit.
        if (state == IDLE || frame_end) begin
            state_n = IDLE;
`ifdef UART_TX_BREAK_EN
            brk_mark_n = 1'b0;
            if (Tx_BREAK) begin
                state_n    = BREAK;
                bit_cnt_n  = '0;
                div_n      = '0;
                samp_n     = '0;
                par_en_n   = parity_mode[0] ^ parity_mode[1];
                two_stop_n = two_stop;
            end else
`endif
            if (Tx_EN && !Tx_READY) begin
                load       = 1'b1;
                state_n    = START;
                shift_n    = hold_q;
                ready_n    = 1'b1;
                div_n      = '0;
                samp_n     = '0;
                par_en_n   = parity_mode[0] ^ parity_mode[1];
                par_bit_n  = (^hold_q) ^ parity_mode[1];
                two_stop_n = two_stop;
            end
        end

        // A slot freed by this edge's load is already available to a write.
        if (Tx_WR && Tx_EN) begin
            if (Tx_READY || load) begin
                hold_n  = Tx_DATA;
                ready_n = 1'b0;
            end else begin
                ovr_n = 1'b1;
            end
        end

        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shift_n[0];
            PARITY:  txd_n = par_bit_n;
`ifdef UART_TX_BREAK_EN
            BREAK:   txd_n = 1'b0;
`endif
            default: txd_n = 1'b1;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            shift_q    <= '0;
            hold_q     <= '0;
            bit_cnt    <= '0;
            samp_cnt   <= '0;
            div_cnt    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            TxD        <= 1'b1;
            Tx_BUSY    <= 1'b0;
            Tx_READY   <= 1'b1;
            Tx_DONE    <= 1'b0;
            Tx_OVR     <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_mark_q <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            shift_q    <= shift_n;
            hold_q     <= hold_n;
            bit_cnt    <= bit_cnt_n;
            samp_cnt   <= samp_n;
            div_cnt    <= div_n;
            par_en_q   <= par_en_n;
            par_bit_q  <= par_bit_n;
            two_stop_q <= two_stop_n;
            TxD        <= txd_n;
            Tx_BUSY    <= busy_n;
            Tx_READY   <= ready_n;
            Tx_DONE    <= done_n;
            Tx_OVR     <= ovr_n;
`ifdef UART_TX_BREAK_EN
            brk_mark_q <= brk_mark_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: directed frames plus randomized words against a frame-level model.
module tb_uart_tx_param;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  Tx_DATA;
    logic        Tx_WR;
    logic        Tx_EN;
    logic [15:0] baud_div;
    logic [1:0]  parity_mode;
    logic        two_stop;
`ifdef UART_TX_BREAK_EN
    logic        Tx_BREAK;
`endif
    logic        TxD, Tx_BUSY, Tx_READY, Tx_DONE, Tx_OVR;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    bit          m_full;
    logic [7:0]  m_hold;
    logic [7:0]  wq[$];
    bit          exp_bits[$];

    always #5 clk = ~clk;

    uart_tx_param #(.DATA_W(8), .OVERSAMPLE(16), .DIV_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .Tx_DATA     (Tx_DATA),
        .Tx_WR       (Tx_WR),
        .Tx_EN       (Tx_EN),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
`ifdef UART_TX_BREAK_EN
        .Tx_BREAK    (Tx_BREAK),
`endif
        .TxD         (TxD),
        .Tx_BUSY     (Tx_BUSY),
        .Tx_READY    (Tx_READY),
        .Tx_DONE     (Tx_DONE),
        .Tx_OVR      (Tx_OVR)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line levels of one frame, one entry per bit period.
    task automatic model_frame(input logic [7:0] d, input logic [1:0] pm, input bit ts);
        int unsigned ones;
        ones = $countones(d);
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(((d >> i) & 8'd1) != 8'd0);
        if (pm == 2'b01) exp_bits.push_back(ones % 2 == 1);
        else if (pm == 2'b10) exp_bits.push_back(ones % 2 == 0);
        exp_bits.push_back(1'b1);
        if (ts) exp_bits.push_back(1'b1);
    endtask

    task automatic write_word(input logic [7:0] d);
        bit acc;
        acc = Tx_EN && !m_full;
        Tx_WR = 1'b1;
        Tx_DATA = d;
        @(posedge clk); #1;
        Tx_WR = 1'b0;
        if (acc) begin
            m_full = 1'b1;
            m_hold = d;
        end
        chk("wr_ready", Tx_READY, !m_full);
        chk("wr_ovr", Tx_OVR, Tx_EN && !acc);
        chk("wr_txd_idle", TxD, 1);
    endtask

    // Entered one step after the edge on which the start bit began.
    task automatic run_frame(input logic [7:0] d, input logic [1:0] pm, input bit ts,
                             input logic [1:0] npm, input bit nts, input int unsigned drop_en_at);
        int unsigned bp, nclk;
        bit exp_ovr;
        bp = 16 * (int'(baud_div) + 1);
        model_frame(d, pm, ts);
        nclk = bp * exp_bits.size();
        for (int unsigned c = 0; c < nclk; c++) begin
            if (c % bp == 0 || c % bp == bp / 2 || c % bp == bp - 1)
                chk($sformatf("txd_bit%0d_c%0d", c / bp, c), TxD, exp_bits[c / bp]);
            if (c == 0) begin
                chk("busy_start", Tx_BUSY, 1);
                chk("ready_start", Tx_READY, !m_full);
            end
            if (c == bp * 2 + 3) begin
                parity_mode = 2'($urandom_range(3));
                two_stop = 1'($urandom_range(1));
            end
            if (c == nclk - 3) begin
                parity_mode = npm;
                two_stop = nts;
            end
            if (drop_en_at != 0 && c == drop_en_at) Tx_EN = 1'b0;
            exp_ovr = 1'b0;
            Tx_WR = 1'b0;
            if (c >= 1 && wq.size() > 0) begin
                Tx_WR = 1'b1;
                Tx_DATA = wq.pop_front();
                if (Tx_EN) begin
                    if (m_full) exp_ovr = 1'b1;
                    else begin
                        m_full = 1'b1;
                        m_hold = Tx_DATA;
                    end
                end
            end
            @(posedge clk); #1;
            Tx_WR = 1'b0;
            if (c < 8) begin
                chk("ovr", Tx_OVR, exp_ovr);
                chk("ready", Tx_READY, !m_full);
            end
            if (c + 2 >= nclk) chk("done", Tx_DONE, c == nclk - 1);
        end
        if (m_full && Tx_EN) begin
            chk("chain_txd", TxD, 0);
            chk("chain_busy", Tx_BUSY, 1);
            chk("chain_ready", Tx_READY, 1);
        end else begin
            chk("end_txd", TxD, 1);
            chk("end_busy", Tx_BUSY, 0);
            chk("end_ready", Tx_READY, !m_full);
        end
    endtask

    task automatic send_idle(input logic [7:0] d, input logic [1:0] pm, input bit ts);
        parity_mode = pm;
        two_stop = ts;
        write_word(d);
        @(posedge clk); #1;
        m_full = 1'b0;
        run_frame(d, pm, ts, pm, ts, 0);
        @(posedge clk); #1;
        chk("done_clear", Tx_DONE, 0);
        chk("idle_txd", TxD, 1);
    endtask

    initial begin
        logic [7:0]  rd;
        logic [1:0]  rpm;
        bit          rts;

        reset = 1'b0;
        Tx_WR = 1'b1;
        Tx_DATA = 8'h77;
        Tx_EN = 1'b1;
        baud_div = 16'd1;
        parity_mode = 2'b00;
        two_stop = 1'b0;
`ifdef UART_TX_BREAK_EN
        Tx_BREAK = 1'b0;
`endif
        m_full = 1'b0;
        m_hold = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", TxD, 1);
        chk("rst_busy", Tx_BUSY, 0);
        chk("rst_ready", Tx_READY, 1);
        chk("rst_done", Tx_DONE, 0);
        chk("rst_ovr", Tx_OVR, 0);
        Tx_WR = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", Tx_READY, 1);
        chk("post_rst_busy", Tx_BUSY, 0);

        send_idle(8'hA5, 2'b00, 1'b0);
        send_idle(8'h03, 2'b01, 1'b1);
        send_idle(8'h03, 2'b10, 1'b0);
        send_idle(8'h5A, 2'b11, 1'b1);

        // Back-to-back with an overflowing third write.
        parity_mode = 2'b00;
        two_stop = 1'b0;
        write_word(8'h55);
        @(posedge clk); #1;
        m_full = 1'b0;
        wq.push_back(8'h0F);
        wq.push_back(8'hEE);
        run_frame(8'h55, 2'b00, 1'b0, 2'b01, 1'b1, 0);
        chk("hold_kept", m_hold, 8'h0F);
        m_full = 1'b0;
        run_frame(8'h0F, 2'b01, 1'b1, 2'b00, 1'b0, 0);

        // Reset during data bit 3.
        parity_mode = 2'b00;
        two_stop = 1'b0;
        write_word(8'hC6);
        @(posedge clk); #1;
        m_full = 1'b0;
        repeat (4 * 32 + 10) @(posedge clk);
        #1;
        chk("pre_rst_bit3", TxD, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("midrst_txd", TxD, 1);
        chk("midrst_busy", Tx_BUSY, 0);
        chk("midrst_ready", Tx_READY, 1);
        send_idle(8'h96, 2'b00, 1'b0);

        // Enable dropped mid-frame with a word held.
        parity_mode = 2'b10;
        two_stop = 1'b0;
        write_word(8'h3C);
        @(posedge clk); #1;
        m_full = 1'b0;
        wq.push_back(8'hC3);
        run_frame(8'h3C, 2'b10, 1'b0, 2'b10, 1'b0, 100);
        repeat (20) @(posedge clk);
        #1;
        chk("dis_txd", TxD, 1);
        chk("dis_ready", Tx_READY, 0);
        chk("dis_busy", Tx_BUSY, 0);
        write_word(8'h11);
        Tx_EN = 1'b1;
        @(posedge clk); #1;
        m_full = 1'b0;
        run_frame(8'hC3, 2'b10, 1'b0, 2'b00, 1'b0, 0);
        @(posedge clk); #1;

        // Randomized words, framing and divisor.
        for (int i = 0; i < 8; i++) begin
            rd = 8'($urandom);
            rpm = 2'($urandom_range(3));
            rts = 1'($urandom_range(1));
            baud_div = 16'($urandom_range(2));
            send_idle(rd, rpm, rts);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised, double-buffered UART transmitter. It is the next-generation serial TX path beside the existing receiver and baud logic. It supports configurable data width, runtime parity mode, 1 or 2 stop bits, and a runtime baud divisor with built-in oversampling. A one-entry holding register accepts the next byte while the current frame shifts, which allows back-to-back frames with no idle gap.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9; sent LSB first.
OVERSAMPLE, 16, sample ticks per bit period; legal range 4..32.
DIV_W, 16, width of the baud divisor input.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-low reset.
Tx_DATA  input  DATA_W  byte to send; sampled when Tx_WR=1.
Tx_WR  input  1  write strobe, one clk per word.
Tx_EN  input  1  transmitter enable.
baud_div  input  DIV_W  one sample tick every baud_div+1 clks.
parity_mode  input  2  00 none, 01 even, 10 odd, 11 none.
two_stop  input  1  1 = two stop bits.
TxD  output  1  serial line; idles high.
Tx_BUSY  output  1  frame in progress.
Tx_READY  output  1  holding register empty.
Tx_DONE  output  1  one-clk pulse at end of the last stop bit.
Tx_OVR  output  1  one-clk pulse when a write is dropped.

Behaviour:
- Reset (reset=0 at a clk edge) sets: TxD=1, Tx_BUSY=0, Tx_READY=1, Tx_DONE=0, Tx_OVR=0, FSM=IDLE, and clears the divider, sample counter, bit counter and holding register. Reset wins over every other input. Reset mid-frame aborts the frame, and TxD is 1 after that edge.
- Write acceptance:
  - Tx_WR=1, Tx_EN=1, Tx_READY=1: Tx_DATA is latched into the holding register and Tx_READY=0 from the next cycle.
  - Tx_WR=1 with Tx_READY=0: data is dropped, Tx_OVR pulses, and the holding register is unchanged.
  - Tx_WR=1 with Tx_EN=0: ignored, no Tx_OVR.
- Divider:
  - Counter runs 0..baud_div; tick is high for one clk when counter==baud_div, then the counter wraps to 0.
  - Divider and sample counter are cleared when a frame starts.
  - baud_div=0 gives a tick every clk.
  - Bit period = OVERSAMPLE*(baud_div+1) clks, exact for every bit.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: TxD=1. If Tx_EN=1 and the holding register is full, then at the next edge:
    - holding register → shift register, Tx_READY=1, Tx_BUSY=1, TxD=0, state START;
    - parity_mode and two_stop are latched for this frame; mid-frame changes have no effect.
  - Transition rule: each state lasts OVERSAMPLE ticks and exits when the sample counter reaches OVERSAMPLE-1 on a tick.
  - START → DATA.
  - DATA: TxD = shift[0]. Shift right at the end of each bit. After DATA_W bits, go to PARITY if the latched mode is 01/10, else to STOP1.
  - PARITY: TxD = XOR of the latched word for even, its inverse for odd. Parity is computed from the latched word, never from live Tx_DATA.
  - STOP1: TxD=1. Go to STOP2 if two_stop was latched, else end the frame.
  - STOP2: TxD=1, then end the frame.
  - End of frame: Tx_DONE pulses. If Tx_EN=1 and the holding register is full, go directly to START on the same edge (zero gap between frames). Otherwise go to IDLE and set Tx_BUSY=0.
- Latency: write at edge k (FSM idle) → TxD falls at edge k+1.
- Tx_EN=0 mid-frame: the current frame completes. No new frame starts and the holding content is retained until Tx_EN=1.
- Write on the same edge the FSM empties the holding register: accepted, no Tx_OVR. Tx_READY is evaluated before the load.
- Illegal state encodings go to IDLE with TxD=1.
- All outputs are registered.

Optional Feature:
UART_TX_BREAK_EN.
- Defined:
  - Adds input port Tx_BREAK (1 bit) and state BREAK.
  - In IDLE, or at frame end, Tx_BREAK=1 takes priority over a pending word: enter BREAK, TxD=0, Tx_BUSY=1.
  - BREAK holds for at least one full frame time (the frame length with the latched config) and continues while Tx_BREAK=1.
  - On deassertion, go to STOP1 (one mark bit), then IDLE or START as usual. No Tx_DONE pulse for a break.
  - A break request during a frame waits for that frame's end.
- Undefined: no Tx_BREAK port, no BREAK state; behaviour is exactly as above.

Test Plan:
All cases use DATA_W=8, OVERSAMPLE=16, baud_div=1, so 32 clks/bit.
- Parity off, one stop: write 0xA5 → TxD sequence 0,1,0,1,0,0,1,0,1,1. Each bit is 32 clks. Tx_DONE pulses 320 clks after TxD falls; Tx_BUSY returns to 0.
- Even parity, two stop: write 0x03 → parity bit 0, two stop bits high, frame 384 clks. Odd parity with 0x03 → parity bit 1.
- Back-to-back: write 0x55, then write 0x0F while busy → Tx_READY returns to 1 at the first frame start. The second start bit begins on the same edge the first frame ends (no gap). A third write while the holding register is full → Tx_OVR pulse, and 0x0F is still sent intact.
- Reset mid-frame: reset=0 in DATA bit 3 → TxD=1, Tx_BUSY=0, Tx_READY=1 after that edge. The next write sends a clean frame.
- Tx_EN dropped mid-frame with the holding register full → the current frame finishes and TxD stays 1. Re-enable → the held word starts within 1 clk.
- With UART_TX_BREAK_EN: Tx_BREAK=1 for 100 clks while idle → TxD low for 320 clks (the frame-time minimum), then 32 clks high, then IDLE.
